// File: rtl/fifo_read_checker.sv
// Read-domain consumer for the dual-clock FIFO: pops a programmed number of words,
// checks them against an incrementing sequence from a seed, and reports status.
module fifo_read_checker #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned CWIDTH  = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] seed,
    input  logic [CWIDTH-1:0] num_words,
    input  logic              rempty,
    output logic              rrq,
    input  logic              rdv,
    input  logic [DWIDTH-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] word_cnt,
    output logic [CWIDTH-1:0] err_cnt,
    output logic              err,
    output logic [DWIDTH-1:0] exp_at_err,
    output logic [DWIDTH-1:0] got_at_err,
    output logic              spurious,
    output logic              timeout
);

    localparam int unsigned OWIDTH = $clog2(MAX_OUT + 1);
    localparam int unsigned TWIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CWIDTH-1:0] target;
    logic [CWIDTH-1:0] issued;
    logic [CWIDTH-1:0] issued_inc;
    logic [DWIDTH-1:0] exp;
    logic [OWIDTH-1:0] outstanding;
    logic [TWIDTH-1:0] wait_cnt;
    logic              active;
    logic              rdv_ok;
    logic              drain_expire;

    // A return only counts against reads already outstanding before this edge.
    assign active       = (state == RUN) || (state == DRAIN);
    assign rdv_ok       = rdv && active && (outstanding != '0);
    assign issued_inc   = issued + CWIDTH'(rrq);
    assign drain_expire = (state == DRAIN) && (outstanding != '0) && !rdv
                          && (wait_cnt == TWIDTH'(TIMEOUT - 1));

    always_ff @(posedge rclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_words == '0) ? DONE : RUN;
            RUN:     if (issued_inc == target) state_next = DRAIN;
            DRAIN:   if ((outstanding == '0) || drain_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rrq is held low during the reset cycle even if the old state was RUN.
    always_comb begin
        rrq  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: begin
                busy = 1'b1;
                rrq  = !rst && !rempty && (issued < target)
                       && (outstanding < OWIDTH'(MAX_OUT));
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            target      <= '0;
            issued      <= '0;
            exp         <= '0;
            outstanding <= '0;
            wait_cnt    <= '0;
            word_cnt    <= '0;
            err_cnt     <= '0;
            err         <= 1'b0;
            exp_at_err  <= '0;
            got_at_err  <= '0;
            spurious    <= 1'b0;
            timeout     <= 1'b0;
        end else if ((state == IDLE) && start) begin
            target      <= num_words;
            exp         <= seed;
            issued      <= '0;
            outstanding <= '0;
            wait_cnt    <= '0;
            word_cnt    <= '0;
            err_cnt     <= '0;
            err         <= 1'b0;
            exp_at_err  <= '0;
            got_at_err  <= '0;
            spurious    <= rdv;
            timeout     <= 1'b0;
        end else begin
            if (rrq) begin
                issued <= issued_inc;
            end

            case ({rrq, rdv_ok})
                2'b10:   outstanding <= outstanding + OWIDTH'(1);
                2'b01:   outstanding <= outstanding - OWIDTH'(1);
                default: ;
            endcase

            if (rdv_ok) begin
                word_cnt <= word_cnt + CWIDTH'(1);
                exp      <= exp + DWIDTH'(1);
                if (rdata != exp) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CWIDTH'(1);
                    end
                    if (!err) begin
                        exp_at_err <= exp;
                        got_at_err <= rdata;
                    end
                    err <= 1'b1;
                end
            end

            if (rdv && !rdv_ok) begin
                spurious <= 1'b1;
            end

            if (drain_expire) begin
                timeout <= 1'b1;
            end

            // Wait counter only runs in DRAIN and restarts on every return.
            if ((state != DRAIN) || rdv) begin
                wait_cnt <= '0;
            end else if (wait_cnt != TWIDTH'(TIMEOUT)) begin
                wait_cnt <= wait_cnt + TWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: a FIFO read-port model feeds directed runs and a
// monitor scores each done pulse against the queued expected run summary.
module tb_fifo_read_checker;

    logic        rclk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [15:0] num_words;
    logic        rempty;
    logic        rrq;
    logic        rdv;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic        err;
    logic [15:0] exp_at_err;
    logic [15:0] got_at_err;
    logic        spurious;
    logic        timeout;

    always #5 rclk = ~rclk;

    fifo_read_checker #(
        .DWIDTH (16),
        .CWIDTH (16),
        .TIMEOUT(64),
        .MAX_OUT(3)
    ) dut (
        .rclk      (rclk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .num_words (num_words),
        .rempty    (rempty),
        .rrq       (rrq),
        .rdv       (rdv),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .err       (err),
        .exp_at_err(exp_at_err),
        .got_at_err(got_at_err),
        .spurious  (spurious),
        .timeout   (timeout)
    );

    typedef struct {
        logic [15:0] word_cnt;
        logic [15:0] err_cnt;
        logic        err;
        logic [15:0] exp_at_err;
        logic [15:0] got_at_err;
        logic        spurious;
        logic        timeout;
        int          rrqs;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    bit          drop_q[$];
    int          checks = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          pops = 0;
    int          stall_at_pop = 0;
    int          stall_len = 0;
    int          stall_left = 0;
    bit          inject_rdv = 1'b0;

    bit          m_pop;
    bit          m_inj;
    bit          m_drop;
    logic [15:0] m_word;

    int          mon_rrq_cnt;
    bit          mon_prev_done;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [15:0] wc, input logic [15:0] ec, input logic e,
                            input logic [15:0] ea, input logic [15:0] ga,
                            input logic sp, input logic to, input int rq);
        exp_t x;
        x.word_cnt   = wc;
        x.err_cnt    = ec;
        x.err        = e;
        x.exp_at_err = ea;
        x.got_at_err = ga;
        x.spurious   = sp;
        x.timeout    = to;
        x.rrqs       = rq;
        exp_q.push_back(x);
    endtask

    task automatic load(input logic [15:0] first, input int n, input bit drop_last);
        fifo_q.delete();
        drop_q.delete();
        pops         = 0;
        stall_at_pop = 0;
        stall_len    = 0;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(first + 16'(i));
            drop_q.push_back(drop_last && (i == n - 1));
        end
        @(posedge rclk); #1;
    endtask

    task automatic start_run(input logic [15:0] s, input logic [15:0] n);
        seed      = s;
        num_words = n;
        start     = 1'b1;
        @(posedge rclk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int base;
        bit seen;
        base = done_seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge rclk); #1;
            if (done_seen != base) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: got no done pulse, expected one within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_rrq"},        32'(rrq),        32'd0);
        check({tag, "_word_cnt"},   32'(word_cnt),   32'd0);
        check({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_exp_at_err"}, 32'(exp_at_err), 32'd0);
        check({tag, "_got_at_err"}, 32'(got_at_err), 32'd0);
        check({tag, "_spurious"},   32'(spurious),   32'd0);
        check({tag, "_timeout"},    32'(timeout),    32'd0);
    endtask

    // FIFO read-port model: pop on rrq at the edge, return data one cycle later.
    initial begin
        rdv    = 1'b0;
        rdata  = 16'h0000;
        rempty = 1'b1;
        forever begin
            @(negedge rclk);
            m_pop = rrq;
            m_inj = inject_rdv;
            @(posedge rclk); #1;
            rdv = 1'b0;
            if (m_pop && (fifo_q.size() > 0)) begin
                m_word = fifo_q.pop_front();
                m_drop = drop_q.pop_front();
                pops++;
                if (!m_drop) begin
                    rdv   = 1'b1;
                    rdata = m_word;
                end
                if (pops == stall_at_pop) stall_left = stall_len;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            if (m_inj) begin
                rdv   = 1'b1;
                rdata = 16'h5555;
            end
            rempty = (fifo_q.size() == 0) || (stall_left > 0);
        end
    end

    // Monitor: scores every done pulse against the oldest queued expectation.
    initial begin
        mon_rrq_cnt   = 0;
        mon_prev_done = 1'b0;
        forever begin
            @(negedge rclk);
            if (rst) begin
                mon_rrq_cnt   = 0;
                mon_prev_done = 1'b0;
            end else begin
                if (rempty) check("rrq_while_empty", 32'(rrq), 32'd0);
                if (rrq) mon_rrq_cnt++;
                if (done) begin
                    check("done_one_cycle", 32'(mon_prev_done), 32'd0);
                    check("busy_at_done", 32'(busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: got done pulse, expected none");
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("word_cnt",   32'(word_cnt),   32'(mon_e.word_cnt));
                        check("err_cnt",    32'(err_cnt),    32'(mon_e.err_cnt));
                        check("err",        32'(err),        32'(mon_e.err));
                        check("exp_at_err", 32'(exp_at_err), 32'(mon_e.exp_at_err));
                        check("got_at_err", 32'(got_at_err), 32'(mon_e.got_at_err));
                        check("spurious",   32'(spurious),   32'(mon_e.spurious));
                        check("timeout",    32'(timeout),    32'(mon_e.timeout));
                        check("rrq_pulses", 32'(mon_rrq_cnt), 32'(mon_e.rrqs));
                    end
                    mon_rrq_cnt = 0;
                    done_seen++;
                end
                mon_prev_done = done;
            end
        end
    end

    initial begin
        int done_before;
        rst       = 1'b1;
        start     = 1'b0;
        seed      = 16'h0000;
        num_words = 16'h0000;
        repeat (2) @(posedge rclk);
        #1;
        rst = 1'b0;
        check_all_clear("reset");

        // Happy path
        load(16'h0010, 8, 1'b0);
        push_exp(16'd8, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8);
        start_run(16'h0010, 16'd8);
        wait_done(40, "happy_done");

        // Sequence wrap with a 5-cycle empty stall after the second pop
        load(16'hFFFE, 4, 1'b0);
        stall_at_pop = 2;
        stall_len    = 5;
        push_exp(16'd4, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4);
        start_run(16'hFFFE, 16'd4);
        wait_done(40, "wrap_done");

        // Two corrupted words; the first one is captured
        load(16'h0000, 6, 1'b0);
        fifo_q[2] = 16'hDEAD;
        fifo_q[4] = 16'hBEEF;
        push_exp(16'd6, 16'd2, 1'b1, 16'h0002, 16'hDEAD, 1'b0, 1'b0, 6);
        start_run(16'h0000, 16'd6);
        wait_done(40, "mismatch_done");

        // Last return is dropped, so DRAIN must time out
        load(16'h0100, 4, 1'b1);
        push_exp(16'd3, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4);
        start_run(16'h0100, 16'd4);
        wait_done(200, "timeout_done");

        // Zero-length run completes immediately and clears the sticky timeout
        load(16'h0000, 0, 1'b0);
        push_exp(16'd0, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        start_run(16'h1234, 16'd0);
        wait_done(3, "zero_done");

        // Stray return while idle
        inject_rdv = 1'b1;
        @(posedge rclk); #1;
        inject_rdv = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        check("idle_spurious", 32'(spurious), 32'd1);
        check("idle_word_cnt", 32'(word_cnt), 32'd0);

        // A second start during a run must be ignored
        load(16'h0020, 6, 1'b0);
        stall_at_pop = 1;
        stall_len    = 4;
        push_exp(16'd6, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 6);
        start_run(16'h0020, 16'd6);
        repeat (2) @(posedge rclk);
        #1;
        check("midrun_busy", 32'(busy), 32'd1);
        start_run(16'h0999, 16'd2);
        wait_done(40, "midrun_done");
        repeat (10) @(posedge rclk);
        #1;

        // Reset mid-run aborts without a done pulse
        load(16'h0040, 8, 1'b0);
        start_run(16'h0040, 16'd8);
        repeat (3) @(posedge rclk);
        #1;
        done_before = done_seen;
        rst = 1'b1;
        @(negedge rclk);
        check("rst_cycle_rrq", 32'(rrq), 32'd0);
        @(posedge rclk); #1;
        rst = 1'b0;
        check_all_clear("midrun_rst");
        fifo_q.delete();
        drop_q.delete();
        repeat (10) @(posedge rclk);
        #1;
        check("rst_no_done", 32'(done_seen), 32'(done_before));
        check("rst_spurious", 32'(spurious), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
